// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//   Builds RV32I instruction words from an opcode, function fields, register
//   indices and a signed immediate. This is the inverse of the immediate
//   extender. The immediate is range- and alignment-checked, then scattered
//   into the format's bit positions. Illegal requests yield a NOP with out_err
//   set. Output words leave through a registered valid/ready stage that has a
//   2-entry skid buffer (main + skid).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request present
//   in_ready   encoder can accept (registered state, forced low during rst)
//   in_opcode  ins[6:0]
//   in_funct3  ins[14:12]
//   in_funct7  ins[31:25] for R-type and shift-immediates
//   in_rd/in_rs1/in_rs2  register indices
//   in_imm     signed immediate (byte offset for B/J, full value for U)
//   out_valid  word available
//   out_ready  consumer takes word
//   out_ins    encoded instruction
//   out_err    out_ins is a NOP substituted for an illegal request
//   err_count  saturating count of errored words delivered
// -----------------------------------------------------------------------------
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_ins,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [6:0]  OP_R      = 7'h33;
    localparam logic [6:0]  OP_IMM    = 7'h13;
    localparam logic [6:0]  OP_LOAD   = 7'h03;
    localparam logic [6:0]  OP_JALR   = 7'h67;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [6:0]  OP_JAL    = 7'h6F;
    localparam logic [6:0]  OP_LUI    = 7'h37;
    localparam logic [6:0]  OP_AUIPC  = 7'h17;
    localparam logic [31:0] NOP_INS   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Immediate checks. A value fits an N-bit signed field when every bit
    // above the field's sign bit equals that sign bit.
    // ------------------------------------------------------------------
    logic fits12;
    logic fits13;
    logic fits21;
    logic is_shift;
    logic shamt_ok;
    logic shift_f7_ok;

    assign fits12      = (in_imm[31:11] == {21{in_imm[11]}});
    assign fits13      = (in_imm[31:12] == {20{in_imm[12]}});
    assign fits21      = (in_imm[31:20] == {12{in_imm[20]}});
    assign is_shift    = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign shamt_ok    = (in_imm[31:5] == 27'd0);
    // funct7 0x20 selects SRAI; it has no meaning for SLLI.
    assign shift_f7_ok = (in_funct7 == 7'h00) ||
                         ((in_funct7 == 7'h20) && (in_funct3 == 3'b101));

    logic [31:0] enc_ins;
    logic        enc_err;

    always_comb begin
        enc_ins = 32'h0;
        enc_err = 1'b0;
        case (in_opcode)
            OP_R: begin
                enc_ins = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_IMM: begin
                if (is_shift) begin
                    enc_err = !shamt_ok || !shift_f7_ok;
                    enc_ins = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                end else begin
                    enc_err = !fits12;
                    enc_ins = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                end
            end
            OP_LOAD, OP_JALR: begin
                enc_err = !fits12;
                enc_ins = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_STORE: begin
                enc_err = !fits12;
                enc_ins = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            OP_BRANCH: begin
                enc_err = !fits13 || in_imm[0];
                enc_ins = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
            end
            OP_JAL: begin
                enc_err = !fits21 || in_imm[0];
                enc_ins = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, in_opcode};
            end
            OP_LUI, OP_AUIPC: begin
                enc_err = (in_imm[11:0] != 12'd0);
                enc_ins = {in_imm[31:12], in_rd, in_opcode};
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        if (enc_err) begin
            enc_ins = NOP_INS;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: main register drives out_*, skid holds the word that
    // arrives while main is stalled.
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;
    logic [31:0]            main_ins_reg;
    logic                   main_err_reg;
    logic [31:0]            skid_ins_reg;
    logic                   skid_err_reg;
    logic [ERR_CNT_W-1:0]   err_count_reg;

    logic accept;
    logic deliver;

    // The rst gate holds in_ready low during reset. It has no path from out_ready.
    assign in_ready  = in_ready_reg && !rst;
    assign out_valid = out_valid_reg;
    assign out_ins   = main_ins_reg;
    assign out_err   = main_err_reg;
    assign err_count = err_count_reg;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            main_ins_reg  <= 32'h0;
            main_err_reg  <= 1'b0;
            skid_ins_reg  <= 32'h0;
            skid_err_reg  <= 1'b0;
            err_count_reg <= '0;
        end else begin
            if (deliver && main_err_reg && (err_count_reg != '1)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end

            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ins_reg  <= enc_ins;
                        main_err_reg  <= enc_err;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_ins_reg <= enc_ins;
                        main_err_reg <= enc_err;
                    end else if (accept) begin
                        skid_ins_reg <= enc_ins;
                        skid_err_reg <= enc_err;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_TWO;
                    end else if (deliver) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a delivery can happen.
                    if (deliver) begin
                        main_ins_reg <= skid_ins_reg;
                        main_err_reg <= skid_err_reg;
                        in_ready_reg <= 1'b1;
                        state_reg    <= ST_ONE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
